axi_lite_cmd_master: RTL and testbench

- Upstream companion to the AXI-Lite register slave. Converts a simple single-beat command/response interface (address, data, strobe, read/write flag) into AXI4-Lite master transactions.
- Used by test controllers, debug bridges and on-chip sequencers to drive AXI-Lite register blocks.
- One transaction outstanding at a time, with an optional watchdog timeout.

---
 rtl/axi_lite_cmd_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
// Turns a single-beat command/response handshake into one AXI4-Lite master
// transaction at a time, with an optional per-transaction watchdog.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_WRITE | AW and W valids presented, each drops after its own handshake
// ST_WRESP | both write beats accepted, bready high waiting for B
// ST_READ  | arvalid presented, waiting for AR handshake
// ST_RDATA | rready high waiting for R
// ST_RESP  | response presented upstream, held until rsp_ready
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_data,
    input  logic [STROBE_WIDTH-1:0] i_cmd_strb,

    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_wr,
    output logic [1:0]              o_rsp_resp,
    output logic                    o_rsp_timeout,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,

    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STROBE_WIDTH-1:0] o_wstrb,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    input  logic [1:0]              i_bresp,

    output logic                    o_arvalid,
    input  logic                    i_arready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    input  logic [1:0]              i_rresp,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value seen on the edge where the count reaches TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] RESP_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_READ,
        ST_RDATA,
        ST_RESP
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    wd_expired;
    logic                    rsp_hs;
    logic                    aw_pend;
    logic                    w_pend;

    logic                    cmd_ready_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STROBE_WIDTH-1:0] wstrb_q;
    logic                    awvalid_q;
    logic                    wvalid_q;
    logic                    bready_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    rsp_valid_q;
    logic                    rsp_wr_q;
    logic [1:0]              rsp_resp_q;
    logic                    rsp_timeout_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    // Watchdog count and expiry; only the four AXI-wait states consume budget.
    always_comb begin
        cnt_d      = cnt_q;
        wd_expired = 1'b0;
        if ((TIMEOUT_CYCLES > 0) &&
            (state_q inside {ST_WRITE, ST_WRESP, ST_READ, ST_RDATA})) begin
            cnt_d      = cnt_q + CNT_W'(1);
            wd_expired = (cnt_q == CNT_LAST);
        end
    end

    // Handshake qualifiers used by the FSM.
    always_comb begin
        aw_pend = awvalid_q && !i_awready;
        w_pend  = wvalid_q && !i_wready;
        // A slave response landing on the expiry edge still completes normally.
        rsp_hs  = ((state_q == ST_WRESP) && bready_q && i_bvalid) ||
                  ((state_q == ST_RDATA) && rready_q && i_rvalid);
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wd_expired && !rsp_hs) begin
                // Abandon the bus transaction; a late slave response is never
                // accepted because every ready is dropped here.
                awvalid_q     <= 1'b0;
                wvalid_q      <= 1'b0;
                bready_q      <= 1'b0;
                arvalid_q     <= 1'b0;
                rready_q      <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_wr_q      <= wr_q;
                rsp_resp_q    <= RESP_TIMEOUT;
                rsp_timeout_q <= 1'b1;
                rsp_data_q    <= '0;
                state_q       <= ST_RESP;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (cmd_ready_q && i_cmd_valid) begin
                            cmd_ready_q <= 1'b0;
                            cnt_q       <= '0;
                            wr_q        <= i_cmd_wr;
                            addr_q      <= i_cmd_addr;
                            wdata_q     <= i_cmd_data;
                            wstrb_q     <= i_cmd_strb;
                            if (i_cmd_wr) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= ST_WRITE;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= ST_READ;
                            end
                        end else begin
                            cmd_ready_q <= 1'b1;
                        end
                    end
                    ST_WRITE: begin
                        awvalid_q <= aw_pend;
                        wvalid_q  <= w_pend;
                        if (!aw_pend && !w_pend) begin
                            bready_q <= 1'b1;
                            state_q  <= ST_WRESP;
                        end
                    end
                    ST_WRESP: begin
                        if (rsp_hs) begin
                            bready_q      <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_wr_q      <= 1'b1;
                            rsp_resp_q    <= i_bresp;
                            rsp_timeout_q <= 1'b0;
                            rsp_data_q    <= '0;
                            state_q       <= ST_RESP;
                        end
                    end
                    ST_READ: begin
                        if (arvalid_q && i_arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (rsp_hs) begin
                            rready_q      <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_wr_q      <= 1'b0;
                            rsp_resp_q    <= i_rresp;
                            rsp_timeout_q <= 1'b0;
                            rsp_data_q    <= i_rdata;
                            state_q       <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        // cmd_ready comes back one cycle after re-entering IDLE.
                        if (i_rsp_ready) begin
                            rsp_valid_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_cmd_ready   = cmd_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_wr      = rsp_wr_q;
    assign o_rsp_resp    = rsp_resp_q;
    assign o_rsp_timeout = rsp_timeout_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_awvalid     = awvalid_q;
    assign o_awaddr      = addr_q;
    assign o_wvalid      = wvalid_q;
    assign o_wdata       = wdata_q;
    assign o_wstrb       = wstrb_q;
    assign o_bready      = bready_q;
    assign o_arvalid     = arvalid_q;
    assign o_araddr      = addr_q;
    assign o_rready      = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a 16-cycle watchdog.
module tb_axi_lite_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_wr;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_data;
    logic [SW-1:0] i_cmd_strb;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic          o_rsp_wr;
    logic [1:0]    o_rsp_resp;
    logic          o_rsp_timeout;
    logic [DW-1:0] o_rsp_data;
    logic          o_awvalid;
    logic          i_awready;
    logic [AW-1:0] o_awaddr;
    logic          o_wvalid;
    logic          i_wready;
    logic [DW-1:0] o_wdata;
    logic [SW-1:0] o_wstrb;
    logic          i_bvalid;
    logic          o_bready;
    logic [1:0]    i_bresp;
    logic          o_arvalid;
    logic          i_arready;
    logic [AW-1:0] o_araddr;
    logic          i_rvalid;
    logic          o_rready;
    logic [1:0]    i_rresp;
    logic [DW-1:0] i_rdata;

    int n_total = 0;
    int n_bad   = 0;

    axi_lite_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .STROBE_WIDTH  (SW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_wr     (i_cmd_wr),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_data   (i_cmd_data),
        .i_cmd_strb   (i_cmd_strb),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_wr     (o_rsp_wr),
        .o_rsp_resp   (o_rsp_resp),
        .o_rsp_timeout(o_rsp_timeout),
        .o_rsp_data   (o_rsp_data),
        .o_awvalid    (o_awvalid),
        .i_awready    (i_awready),
        .o_awaddr     (o_awaddr),
        .o_wvalid     (o_wvalid),
        .i_wready     (i_wready),
        .o_wdata      (o_wdata),
        .o_wstrb      (o_wstrb),
        .i_bvalid     (i_bvalid),
        .o_bready     (o_bready),
        .i_bresp      (i_bresp),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .o_araddr     (o_araddr),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .i_rresp      (i_rresp),
        .i_rdata      (i_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command for exactly one edge; returns in cycle 1 after accept.
    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [SW-1:0] strb);
        check_val("cmd_ready_before_send", {63'd0, o_cmd_ready}, 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_wr    = wr;
        i_cmd_addr  = addr;
        i_cmd_data  = data;
        i_cmd_strb  = strb;
        tick();
        i_cmd_valid = 1'b0;
        check_val("cmd_ready_after_accept", {63'd0, o_cmd_ready}, 64'd0);
    endtask

    task automatic finish_rsp();
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check_val("rsp_valid_drop", {63'd0, o_rsp_valid}, 64'd0);
        check_val("cmd_ready_idle_entry", {63'd0, o_cmd_ready}, 64'd0);
        tick();
        check_val("cmd_ready_back", {63'd0, o_cmd_ready}, 64'd1);
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_time_limit: got=expired exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b0;
        i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_data = '0; i_cmd_strb = '0;
        i_rsp_ready = 1'b0;
        i_awready = 1'b1; i_wready = 1'b1; i_arready = 1'b1;
        i_bvalid = 1'b0; i_bresp = 2'b00;
        i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = '0;

        // reset values
        tick();
        tick();
        check_val("rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
        check_val("rst_valids", {59'd0, o_awvalid, o_wvalid, o_arvalid, o_rsp_valid, o_bready}, 64'd0);
        check_val("rst_rready", {63'd0, o_rready}, 64'd0);
        check_val("rst_awaddr", {32'd0, o_awaddr}, 64'd0);
        check_val("rst_rsp_fields", {28'd0, o_rsp_resp, o_rsp_timeout, o_rsp_wr, o_rsp_data}, 64'd0);
        rst = 1'b1;
        tick();
        check_val("cmd_ready_after_rst", {63'd0, o_cmd_ready}, 64'd1);

        // best-case write: valids in cycle 1, rsp_valid in cycle 3
        send_cmd(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
        check_val("wr1_awvalid", {63'd0, o_awvalid}, 64'd1);
        check_val("wr1_wvalid", {63'd0, o_wvalid}, 64'd1);
        check_val("wr1_wdata", {32'd0, o_wdata}, 64'hDEADBEEF);
        check_val("wr1_wstrb", {60'd0, o_wstrb}, 64'hF);
        tick();
        check_val("wr1_valids_dropped", {62'd0, o_awvalid, o_wvalid}, 64'd0);
        check_val("wr1_bready", {63'd0, o_bready}, 64'd1);
        i_bvalid = 1'b1; i_bresp = 2'b00;
        tick();
        i_bvalid = 1'b0;
        check_val("wr1_rsp_valid_c3", {63'd0, o_rsp_valid}, 64'd1);
        check_val("wr1_bready_drop", {63'd0, o_bready}, 64'd0);
        check_val("wr1_rsp_wr", {63'd0, o_rsp_wr}, 64'd1);
        check_val("wr1_rsp_resp", {62'd0, o_rsp_resp}, 64'd0);
        check_val("wr1_rsp_data", {32'd0, o_rsp_data}, 64'd0);
        finish_rsp();

        // best-case read back
        send_cmd(1'b0, 32'h0, 32'h0, 4'h0);
        check_val("rd1_arvalid", {63'd0, o_arvalid}, 64'd1);
        check_val("rd1_no_aw", {63'd0, o_awvalid}, 64'd0);
        tick();
        check_val("rd1_arvalid_drop", {63'd0, o_arvalid}, 64'd0);
        check_val("rd1_rready", {63'd0, o_rready}, 64'd1);
        i_rvalid = 1'b1; i_rdata = 32'hDEADBEEF; i_rresp = 2'b00;
        tick();
        i_rvalid = 1'b0;
        check_val("rd1_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        check_val("rd1_rsp_data", {32'd0, o_rsp_data}, 64'hDEADBEEF);
        check_val("rd1_rsp_wr", {63'd0, o_rsp_wr}, 64'd0);
        check_val("rd1_rsp_resp", {62'd0, o_rsp_resp}, 64'd0);
        finish_rsp();

        // write with awready delayed: awvalid held cycles 1..5, wvalid only cycle 1
        i_awready = 1'b0;
        send_cmd(1'b1, 32'h40, 32'h11223344, 4'h3);
        check_val("wr2_both_valid", {62'd0, o_awvalid, o_wvalid}, 64'd3);
        for (int k = 2; k <= 5; k++) begin
            tick();
            check_val("wr2_awvalid_held", {63'd0, o_awvalid}, 64'd1);
            check_val("wr2_awaddr_stable", {32'd0, o_awaddr}, 64'h40);
            check_val("wr2_wvalid_low", {63'd0, o_wvalid}, 64'd0);
            check_val("wr2_no_bready", {63'd0, o_bready}, 64'd0);
        end
        i_awready = 1'b1;
        tick();
        check_val("wr2_awvalid_drop", {63'd0, o_awvalid}, 64'd0);
        check_val("wr2_bready", {63'd0, o_bready}, 64'd1);
        i_bvalid = 1'b1; i_bresp = 2'b11;
        tick();
        i_bvalid = 1'b0; i_bresp = 2'b00;
        check_val("wr2_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        check_val("wr2_decerr_pass", {62'd0, o_rsp_resp}, 64'd3);
        check_val("wr2_no_timeout", {63'd0, o_rsp_timeout}, 64'd0);
        finish_rsp();

        // read answered with SLVERR, then response stalled for 10 cycles
        send_cmd(1'b0, 32'h5, 32'h0, 4'h0);
        check_val("rd2_araddr", {32'd0, o_araddr}, 64'h5);
        tick();
        i_rvalid = 1'b1; i_rdata = 32'h12345678; i_rresp = 2'b10;
        tick();
        i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = '0;
        check_val("rd2_rsp_resp", {62'd0, o_rsp_resp}, 64'd2);
        check_val("rd2_rsp_timeout", {63'd0, o_rsp_timeout}, 64'd0);
        check_val("rd2_rsp_data", {32'd0, o_rsp_data}, 64'h12345678);
        i_cmd_valid = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 32'hBAD0; i_cmd_data = 32'hBAD1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val("stall_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
            check_val("stall_rsp_data", {32'd0, o_rsp_data}, 64'h12345678);
            check_val("stall_rsp_resp", {62'd0, o_rsp_resp}, 64'd2);
            check_val("stall_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
            check_val("stall_no_axi", {59'd0, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 64'd0);
        end
        i_cmd_valid = 1'b0;
        finish_rsp();

        // watchdog: arready stuck low, arvalid held exactly 16 cycles
        i_arready = 1'b0;
        send_cmd(1'b0, 32'h80, 32'h0, 4'h0);
        for (int k = 1; k <= TO; k++) begin
            check_val("to_arvalid_held", {63'd0, o_arvalid}, 64'd1);
            check_val("to_no_rsp_yet", {63'd0, o_rsp_valid}, 64'd0);
            tick();
        end
        check_val("to_arvalid_drop", {63'd0, o_arvalid}, 64'd0);
        check_val("to_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        check_val("to_rsp_resp", {62'd0, o_rsp_resp}, 64'd2);
        check_val("to_rsp_timeout", {63'd0, o_rsp_timeout}, 64'd1);
        check_val("to_rsp_data", {32'd0, o_rsp_data}, 64'd0);
        check_val("to_rsp_wr", {63'd0, o_rsp_wr}, 64'd0);
        finish_rsp();
        i_arready = 1'b1;

        // next command after timeout completes normally
        send_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        i_rvalid = 1'b1; i_rdata = 32'h0000AA55; i_rresp = 2'b00;
        tick();
        i_rvalid = 1'b0;
        check_val("post_to_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        check_val("post_to_data", {32'd0, o_rsp_data}, 64'hAA55);
        check_val("post_to_timeout", {63'd0, o_rsp_timeout}, 64'd0);
        finish_rsp();

        // R handshake on the very edge the watchdog would expire: normal completion
        i_arready = 1'b0;
        send_cmd(1'b0, 32'h20, 32'h0, 4'h0);
        repeat (13) tick();
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
        check_val("prio_rready", {63'd0, o_rready}, 64'd1);
        tick();
        check_val("prio_no_rsp_yet", {63'd0, o_rsp_valid}, 64'd0);
        i_rvalid = 1'b1; i_rdata = 32'hCAFEF00D; i_rresp = 2'b00;
        tick();
        i_rvalid = 1'b0;
        i_arready = 1'b1;
        check_val("prio_rsp_valid", {63'd0, o_rsp_valid}, 64'd1);
        check_val("prio_timeout", {63'd0, o_rsp_timeout}, 64'd0);
        check_val("prio_resp", {62'd0, o_rsp_resp}, 64'd0);
        check_val("prio_data", {32'd0, o_rsp_data}, 64'hCAFEF00D);
        finish_rsp();

        // reset while in WRESP abandons the transaction
        send_cmd(1'b1, 32'h30, 32'h55AA55AA, 4'hF);
        tick();
        check_val("rstw_bready", {63'd0, o_bready}, 64'd1);
        rst = 1'b0;
        i_bvalid = 1'b1;
        tick();
        i_bvalid = 1'b0;
        check_val("rstw_axi_idle", {59'd0, o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 64'd0);
        check_val("rstw_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);
        check_val("rstw_awaddr", {32'd0, o_awaddr}, 64'd0);
        rst = 1'b1;
        tick();
        check_val("rstw_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("rstw_no_stale_rsp", {63'd0, o_rsp_valid}, 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
